// File: rtl/irq_controller_if.sv
// Request/ack/register bus between the interrupt controller (slave) and the core/bus side (master).
interface irq_controller_if #(
  parameter int NSRC = 8,
  parameter int DW   = 16
);
  logic [NSRC-1:0] req;
  logic            ack;
  logic            eoi;
  logic            wr_en;
  logic [1:0]      addr;
  logic [DW-1:0]   wr_data;
  logic [DW-1:0]   rd_data;
  logic            interrupt;
  logic [2:0]      irq;
  logic            in_service;

  modport slave  (input  req, ack, eoi, wr_en, addr, wr_data,
                  output rd_data, interrupt, irq, in_service);
  modport master (output req, ack, eoi, wr_en, addr, wr_data,
                  input  rd_data, interrupt, irq, in_service);
endinterface

// File: rtl/irq_controller.sv
// Edge-latched, masked, fixed-priority interrupt controller feeding the MCU core.
// Optional periodic tick on line NSRC-1 when INTC_TICK_EN is defined.
module irq_controller #(
  parameter int NSRC = 8,
  parameter int DW   = 16
`ifdef INTC_TICK_EN
  , parameter logic [15:0] TICK_RELOAD = 16'd25
`endif
) (
  input  logic            clock,
  input  logic            reset,
  irq_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t          state;
  logic [NSRC-1:0] req_d, mask, pending;
  logic [NSRC-1:0] set, clr, active;
  logic [7:0]      mask8, pend8, onehot;
  logic [2:0]      sel, irq_q;
  logic            int_q, insvc_q;
  logic [DW-1:0]   rd_q, rd_next;
  logic            tick;
  logic            unused_wr_bits;

  assign unused_wr_bits = ^bus.wr_data;

`ifdef INTC_TICK_EN
  logic [15:0] tick_reload, tick_cnt;

  // Reload 0 parks the counter and suppresses the tick entirely.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_reload <= TICK_RELOAD;
      tick_cnt    <= TICK_RELOAD;
    end else if (bus.wr_en && bus.addr == 2'd2) begin
      tick_reload <= bus.wr_data[15:0];
      tick_cnt    <= bus.wr_data[15:0];
    end else if (tick_reload != 16'd0) begin
      tick_cnt <= (tick_cnt == 16'd0) ? tick_reload : tick_cnt - 16'd1;
    end
  end

  assign tick = (tick_reload != 16'd0) && (tick_cnt == 16'd0);
`else
  assign tick = 1'b0;
`endif

  always_comb begin
    set = bus.req & ~req_d;
`ifdef INTC_TICK_EN
    set[NSRC-1] = tick;
`endif
  end

  assign mask8  = 8'(mask);
  assign pend8  = 8'(pending);
  assign onehot = 8'd1 << irq_q;
  assign active = pending & mask;

  always_comb begin
    clr = '0;
    if (bus.wr_en && bus.addr == 2'd1) clr = bus.wr_data[NSRC-1:0];
    if (state == REQ && bus.ack)       clr = clr | onehot[NSRC-1:0];
  end

  // Index 0 wins: scan from the top so the lowest set bit is written last.
  always_comb begin
    sel = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (active[i]) sel = 3'(i);
  end

  always_comb begin
    rd_next = '0;
    case (bus.addr)
      2'd0: rd_next = DW'(mask);
      2'd1: rd_next = DW'(pending);
`ifdef INTC_TICK_EN
      2'd2: rd_next = DW'(tick_reload);
`endif
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_d   <= '0;
      mask    <= '0;
      pending <= '0;
      rd_q    <= '0;
    end else begin
      req_d   <= bus.req;
      pending <= (pending & ~clr) | set;
      rd_q    <= rd_next;
      if (bus.wr_en && bus.addr == 2'd0) mask <= bus.wr_data[NSRC-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      int_q   <= 1'b0;
      irq_q   <= '0;
      insvc_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (active != '0) begin
          state <= REQ;
          irq_q <= sel;
          int_q <= 1'b1;
        end
        REQ: if (bus.ack) begin
          state   <= SERVICE;
          int_q   <= 1'b0;
          insvc_q <= 1'b1;
        end else if (!mask8[irq_q] || !pend8[irq_q]) begin
          state <= IDLE;
          int_q <= 1'b0;
        end
        SERVICE: if (bus.eoi) begin
          state   <= IDLE;
          insvc_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.interrupt  = int_q;
  assign bus.irq        = irq_q;
  assign bus.in_service = insvc_q;
  assign bus.rd_data    = rd_q;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboarded bench for irq_controller: expected vectors queued at stimulus, popped on each interrupt rise.
module tb_irq_controller;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0, n_fail = 0, nint = 0, cyc = 0;
  int   exp_q[$];
  logic int_prev = 1'b0;

  irq_controller_if #(.NSRC(8), .DW(16)) bus();
  irq_controller #(.NSRC(8), .DW(16)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bus.wr_en = 1'b1; bus.addr = a; bus.wr_data = d;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    bus.addr = a;
    step();
    d = bus.rd_data;
  endtask

  task automatic do_ack();
    bus.ack = 1'b1; step(); bus.ack = 1'b0;
  endtask

  task automatic do_eoi();
    bus.eoi = 1'b1; step(); bus.eoi = 1'b0;
  endtask

  task automatic wait_int(input int max);
    int n = 0;
    while (!bus.interrupt && n < max) begin step(); n++; end
    chk("int_seen", 32'(bus.interrupt), 1);
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Scoreboard monitor: every rising interrupt must match the oldest queued vector.
  initial forever begin
    @(negedge clock);
    if (!reset && bus.interrupt && !int_prev) begin
      nint++;
      if (exp_q.size() != 0) chk("irq_vec", 32'(bus.irq), 32'(exp_q.pop_front()));
      else chk("spurious_int", {28'd0, bus.interrupt, bus.irq}, 0);
    end
    int_prev = bus.interrupt;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    int t_last, n0;
    bus.req = '0; bus.ack = 1'b0; bus.eoi = 1'b0;
    bus.wr_en = 1'b0; bus.addr = '0; bus.wr_data = '0;
    repeat (3) step();
    chk("rst_int", 32'(bus.interrupt), 0);
    chk("rst_irq", 32'(bus.irq), 0);
    chk("rst_insvc", 32'(bus.in_service), 0);
    chk("rst_rd", 32'(bus.rd_data), 0);
    reset = 1'b0;
`ifdef INTC_TICK_EN
    wr(2, 16'd0);
`endif

    // Single source: pending then interrupt one edge later, ack clears pending.
    wr(0, 16'h00FF);
    bus.req = 8'h04; exp_q.push_back(2);
    step();
    bus.req = '0;
    chk("t1_int_lat", 32'(bus.interrupt), 0);
    bus.addr = 2'd1;
    step();
    chk("t1_int", 32'(bus.interrupt), 1);
    chk("t1_irq", 32'(bus.irq), 2);
    chk("t1_pend", 32'(bus.rd_data), 32'h4);
    do_ack();
    chk("t1_ack_int", 32'(bus.interrupt), 0);
    chk("t1_ack_svc", 32'(bus.in_service), 1);
    rd(1, d);
    chk("t1_pend_clr", 32'(d), 0);
    do_eoi();
    chk("t1_eoi_svc", 32'(bus.in_service), 0);

    // Two simultaneous sources: lower index first, the other right after eoi.
    bus.req = 8'h22; exp_q.push_back(1); exp_q.push_back(5);
    step();
    bus.req = '0;
    wait_int(4);
    chk("t2_irq1", 32'(bus.irq), 1);
    do_ack();
    do_eoi();
    chk("t2_eoi_int", 32'(bus.interrupt), 0);
    step();
    chk("t2_int5", 32'(bus.interrupt), 1);
    chk("t2_irq5", 32'(bus.irq), 5);
    do_ack();
    do_eoi();

    // Higher-priority edge while in REQ does not re-arbitrate.
    bus.req = 8'h08; exp_q.push_back(3);
    step();
    bus.req = '0;
    wait_int(4);
    bus.req = 8'h01; exp_q.push_back(0);
    step();
    bus.req = '0;
    step(); step();
    chk("t3_frozen", 32'(bus.irq), 3);
    do_ack();
    do_eoi();
    step();
    chk("t3_int0", 32'(bus.interrupt), 1);
    chk("t3_irq0", 32'(bus.irq), 0);
    do_ack();
    do_eoi();

    // Masked source latches but stays silent; unmask raises, remask withdraws.
    wr(0, 16'h0000);
    bus.req = 8'h10;
    step();
    bus.req = '0;
    rd(1, d);
    chk("t4_pend", 32'(d), 32'h10);
    step();
    chk("t4_masked", 32'(bus.interrupt), 0);
    exp_q.push_back(4);
    wr(0, 16'h0010);
    step();
    chk("t4_unmask_int", 32'(bus.interrupt), 1);
    chk("t4_unmask_irq", 32'(bus.irq), 4);
    wr(0, 16'h0000);
    step();
    chk("t4_withdraw", 32'(bus.interrupt), 0);
    wr(1, 16'h0010);
    rd(1, d);
    chk("t4_w1c", 32'(d), 0);

    // Edge in the same cycle as W1C of the same bit: set wins.
    bus.req = 8'h40;
    bus.wr_en = 1'b1; bus.addr = 2'd1; bus.wr_data = 16'h0040;
    step();
    bus.wr_en = 1'b0; bus.req = '0;
    rd(1, d);
    chk("t5_set_wins", 32'(d), 32'h40);
    exp_q.push_back(6);
    wr(0, 16'h0040);
    wait_int(4);
    do_ack();
    chk("t5_svc", 32'(bus.in_service), 1);
    chk("t5_rd_mask", 32'(bus.rd_data), 32'h40);

    // Asynchronous reset from SERVICE; a line held high through release is one edge.
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_int", 32'(bus.interrupt), 0);
    chk("t5_rst_svc", 32'(bus.in_service), 0);
    chk("t5_rst_rd", 32'(bus.rd_data), 0);
    bus.req = 8'h08;
    step(); step();
    reset = 1'b0;
    rd(0, d);
    chk("t5_mask_rst", 32'(d), 0);
    rd(1, d);
    chk("t5_held_edge", 32'(d), 32'h08);
`ifdef INTC_TICK_EN
    wr(2, 16'd0);
`endif
    wr(1, 16'h0008);
    bus.req = '0;

    // ack/eoi outside their states are ignored.
    do_ack();
    do_eoi();
    chk("idle_svc", 32'(bus.in_service), 0);
    chk("idle_int", 32'(bus.interrupt), 0);

    // Unmapped address and width clipping of mask.
    wr(3, 16'hFFFF);
    rd(3, d);
    chk("addr3_rd", 32'(d), 0);
`ifndef INTC_TICK_EN
    wr(2, 16'h1234);
    rd(2, d);
    chk("addr2_rd", 32'(d), 0);
`endif
    wr(0, 16'hFFFF);
    rd(0, d);
    chk("mask_clip", 32'(d), 32'h00FF);
    wr(0, 16'h0000);

`ifdef INTC_TICK_EN
    // Tick with reload 4 fires every 5 cycles; reload 0 stops it.
    wr(0, 16'h0080);
    wr(2, 16'd4);
    rd(2, d);
    chk("tick_reload_rd", 32'(d), 32'd4);
    t_last = 0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(7);
      wait_int(8);
      if (k > 0) chk("tick_period", 32'(cyc - t_last), 5);
      t_last = cyc;
      do_ack();
      do_eoi();
    end
    wr(2, 16'd0);
    n0 = nint;
    repeat (15) step();
    chk("tick_off", 32'(nint), 32'(n0));
`else
    t_last = 0; n0 = 0;
`endif

    step();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
